// File: rtl/rvfi_trace_fifo.sv
// rvfi_trace_fifo: retirement-trace queue between the core's retire point
// and the RVFI host consumer. Captures one sanitised packet per retired
// instruction, stamps a 64-bit order number, presents the head packet
// first-word-fall-through, requests a core halt near capacity and counts
// packets lost to overflow.
module rvfi_trace_fifo #(
    parameter int DEPTH       = 8,
    parameter int HALT_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ret_valid,
    input  logic [31:0]                ret_pc_rdata,
    input  logic [31:0]                ret_pc_wdata,
    input  logic [31:0]                ret_insn,
    input  logic                       ret_trap,
    input  logic [4:0]                 ret_rd_addr,
    input  logic [31:0]                ret_rd_wdata,
    input  logic [31:0]                ret_mem_addr,
    input  logic [3:0]                 ret_mem_rmask,
    input  logic [3:0]                 ret_mem_wmask,
    input  logic [31:0]                ret_mem_rdata,
    input  logic [31:0]                ret_mem_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_order,
    output logic [31:0]                out_pc_rdata,
    output logic [31:0]                out_pc_wdata,
    output logic [31:0]                out_insn,
    output logic                       out_trap,
    output logic [4:0]                 out_rd_addr,
    output logic [31:0]                out_rd_wdata,
    output logic [31:0]                out_mem_addr,
    output logic [3:0]                 out_mem_rmask,
    output logic [3:0]                 out_mem_wmask,
    output logic [31:0]                out_mem_rdata,
    output logic [31:0]                out_mem_wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       halt_req,
    output logic                       overflow,
    output logic [15:0]                drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH = CW'(DEPTH - HALT_MARGIN);

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] insn;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } pkt_t;

    pkt_t            mem [DEPTH];
    pkt_t            cap;
    pkt_t            head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [63:0]     order;
    logic [CW-1:0]   next_count;
    logic            push, pop, drop;

    // Handshake decode: a pop frees a slot for a same-cycle push even when full.
    always_comb begin
        pop  = (count != '0) && out_ready;
        push = ret_valid && ((count != FULL) || pop);
        drop = ret_valid && !push;
        next_count = count;
        case ({push, pop})
            2'b10:   next_count = count + CW'(1);
            2'b01:   next_count = count - CW'(1);
            default: next_count = count;
        endcase
    end

    // Capture-time sanitisation: x0 writes and trapped instructions carry no rd/mem effects.
    always_comb begin
        cap           = '0;
        cap.order     = order;
        cap.pc_rdata  = ret_pc_rdata;
        cap.pc_wdata  = ret_pc_wdata;
        cap.insn      = ret_insn;
        cap.trap      = ret_trap;
        cap.rd_addr   = ret_trap ? 5'd0 : ret_rd_addr;
        cap.rd_wdata  = (ret_trap || ret_rd_addr == 5'd0) ? 32'd0 : ret_rd_wdata;
        cap.mem_addr  = ret_mem_addr;
        cap.mem_rmask = ret_trap ? 4'd0 : ret_mem_rmask;
        cap.mem_wmask = ret_trap ? 4'd0 : ret_mem_wmask;
        cap.mem_rdata = ret_mem_rdata;
        cap.mem_wdata = ret_mem_wdata;
    end

    // Packet storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr] <= cap;
    end

    // Pointers, occupancy, order stamp, halt request and overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            order      <= '0;
            halt_req   <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                order  <= order + 64'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count    <= next_count;
            halt_req <= (next_count >= THRESH);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end
        end
    end

    // First-word-fall-through head view.
    assign head          = mem[rd_ptr];
    assign out_valid     = (count != '0);
    assign out_order     = head.order;
    assign out_pc_rdata  = head.pc_rdata;
    assign out_pc_wdata  = head.pc_wdata;
    assign out_insn      = head.insn;
    assign out_trap      = head.trap;
    assign out_rd_addr   = head.rd_addr;
    assign out_rd_wdata  = head.rd_wdata;
    assign out_mem_addr  = head.mem_addr;
    assign out_mem_rmask = head.mem_rmask;
    assign out_mem_wmask = head.mem_wmask;
    assign out_mem_rdata = head.mem_rdata;
    assign out_mem_wdata = head.mem_wdata;

endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// Bench for rvfi_trace_fifo: a per-cycle vector table for the directed
// scenarios, hand sequences for sanitisation and mid-run reset, then
// random traffic against a queue-based reference model.
module tb_rvfi_trace_fifo;

    localparam int DEPTH = 8;
    localparam int HM    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ret_valid;
    logic [31:0] ret_pc_rdata, ret_pc_wdata, ret_insn;
    logic        ret_trap;
    logic [4:0]  ret_rd_addr;
    logic [31:0] ret_rd_wdata, ret_mem_addr;
    logic [3:0]  ret_mem_rmask, ret_mem_wmask;
    logic [31:0] ret_mem_rdata, ret_mem_wdata;
    logic        out_valid, out_ready;
    logic [63:0] out_order;
    logic [31:0] out_pc_rdata, out_pc_wdata, out_insn;
    logic        out_trap;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd_wdata, out_mem_addr;
    logic [3:0]  out_mem_rmask, out_mem_wmask;
    logic [31:0] out_mem_rdata, out_mem_wdata;
    logic [3:0]  count;
    logic        halt_req, overflow;
    logic [15:0] drop_count;

    int tests = 0;
    int fails = 0;

    rvfi_trace_fifo #(.DEPTH(DEPTH), .HALT_MARGIN(HM)) dut (
        .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid),
        .ret_pc_rdata(ret_pc_rdata), .ret_pc_wdata(ret_pc_wdata), .ret_insn(ret_insn),
        .ret_trap(ret_trap), .ret_rd_addr(ret_rd_addr), .ret_rd_wdata(ret_rd_wdata),
        .ret_mem_addr(ret_mem_addr), .ret_mem_rmask(ret_mem_rmask), .ret_mem_wmask(ret_mem_wmask),
        .ret_mem_rdata(ret_mem_rdata), .ret_mem_wdata(ret_mem_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
        .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata), .out_insn(out_insn),
        .out_trap(out_trap), .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
        .out_mem_addr(out_mem_addr), .out_mem_rmask(out_mem_rmask), .out_mem_wmask(out_mem_wmask),
        .out_mem_rdata(out_mem_rdata), .out_mem_wdata(out_mem_wdata),
        .count(count), .halt_req(halt_req), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // One table row: inputs for a cycle and the outputs expected after its edge.
    typedef struct {
        logic        rst;
        logic        rv;
        logic        rdy;
        logic [31:0] pc;
        int          e_cnt;
        logic [63:0] e_ord;
        logic        e_halt;
        logic        e_ov;
        int          e_drop;
    } vec_t;

    typedef struct {
        logic [63:0] order;
        logic [31:0] pc_rdata, pc_wdata, insn;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata, mem_addr;
        logic [3:0]  rmask, wmask;
        logic [31:0] mem_rdata, mem_wdata;
    } pkt_t;

    vec_t vecs[$];
    pkt_t mq[$];
    logic [63:0] m_order;
    logic        m_halt, m_ov;
    int          m_drop;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic rv, input logic rdy, input logic [31:0] pc,
                                input int cnt, input logic [63:0] ord, input logic halt,
                                input logic ov, input int drop);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rdy = rdy; v.pc = pc;
        v.e_cnt = cnt; v.e_ord = ord; v.e_halt = halt; v.e_ov = ov; v.e_drop = drop;
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] pc_of(input logic [63:0] ord);
        return 32'h1000 + 32'(ord) * 4;
    endfunction

    task automatic set_in(input logic rst, input logic rv, input logic rdy, input logic [31:0] pc,
                          input logic trap, input logic [4:0] rd, input logic [31:0] wd,
                          input logic [3:0] rm, input logic [3:0] wm);
        rst_n = rst; ret_valid = rv; out_ready = rdy;
        ret_pc_rdata = pc; ret_pc_wdata = pc + 4; ret_insn = pc ^ 32'h0000_0013;
        ret_trap = trap; ret_rd_addr = rd; ret_rd_wdata = wd;
        ret_mem_addr = pc ^ 32'h8000_0000; ret_mem_rmask = rm; ret_mem_wmask = wm;
        ret_mem_rdata = ~pc; ret_mem_wdata = pc + 32'h55;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pops/pushes on a queue with the rules stated in plain terms.
    task automatic model_step();
        bit   do_pop, do_push;
        pkt_t p;
        if (!rst_n) begin
            mq.delete();
            m_order = 0; m_halt = 0; m_ov = 0; m_drop = 0;
            return;
        end
        do_pop  = (mq.size() > 0) && out_ready;
        do_push = ret_valid && (mq.size() < DEPTH || do_pop);
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            p.order = m_order; p.pc_rdata = ret_pc_rdata; p.pc_wdata = ret_pc_wdata;
            p.insn = ret_insn; p.trap = ret_trap;
            p.rd_addr  = ret_trap ? 5'd0 : ret_rd_addr;
            p.rd_wdata = (ret_trap || ret_rd_addr == 0) ? 32'd0 : ret_rd_wdata;
            p.mem_addr = ret_mem_addr;
            p.rmask = ret_trap ? 4'd0 : ret_mem_rmask;
            p.wmask = ret_trap ? 4'd0 : ret_mem_wmask;
            p.mem_rdata = ret_mem_rdata; p.mem_wdata = ret_mem_wdata;
            mq.push_back(p);
            m_order = m_order + 1;
        end else if (ret_valid) begin
            m_ov = 1;
            if (m_drop < 16'hFFFF) m_drop++;
        end
        m_halt = (mq.size() >= DEPTH - HM);
    endtask

    initial begin
        // ---- build the directed table ----
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // three pushes held, then drained
        for (int i = 0; i < 3; i++) add(1, 1, 0, pc_of(i), i + 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 2 - i, i + 1, 0, 0, 0);
        // six pushes raise halt, one pop drops it
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(1, 1, 0, pc_of(i), i + 1, 0, (i + 1) >= 6, 0, 0);
        add(1, 0, 1, 0, 5, 1, 0, 0, 0);
        // fill, overflow twice, push+pop while full, drain showing order continuity
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 1, 0, pc_of(i), i + 1, 0, (i + 1) >= 6, 0, 0);
        add(1, 1, 0, 32'hBAD0, 8, 0, 1, 1, 1);
        add(1, 1, 0, 32'hBAD4, 8, 0, 1, 1, 2);
        add(1, 1, 1, pc_of(8), 8, 1, 1, 1, 2);
        for (int k = 1; k <= 8; k++) add(1, 0, 1, 0, 8 - k, 1 + k, (8 - k) >= 6, 1, 2);

        // ---- apply table ----
        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].rst, vecs[i].rv, vecs[i].rdy, vecs[i].pc, 0, 5'd3, 32'h77, 4'h1, 4'h0);
            tick();
            chk($sformatf("v%0d count", i), 64'(count), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d valid", i), 64'(out_valid), 64'(vecs[i].e_cnt != 0));
            chk($sformatf("v%0d halt", i), 64'(halt_req), 64'(vecs[i].e_halt));
            chk($sformatf("v%0d overflow", i), 64'(overflow), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d drops", i), 64'(drop_count), 64'(vecs[i].e_drop));
            if (vecs[i].e_cnt != 0) begin
                chk($sformatf("v%0d order", i), out_order, vecs[i].e_ord);
                chk($sformatf("v%0d pc", i), 64'(out_pc_rdata), 64'(pc_of(vecs[i].e_ord)));
                chk($sformatf("v%0d rd_wdata", i), 64'(out_rd_wdata), 64'h77);
            end
        end

        // ---- sanitisation ----
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        set_in(1, 1, 0, 32'h2000, 0, 5'd0, 32'hDEADBEEF, 4'h3, 4'h0); tick();
        set_in(1, 1, 0, 32'h2004, 1, 5'd5, 32'h12345678, 4'hF, 4'hC); tick();
        chk("x0 rd_wdata", 64'(out_rd_wdata), 0);
        chk("x0 pc", 64'(out_pc_rdata), 64'h2000);
        chk("x0 rmask", 64'(out_mem_rmask), 64'h3);
        set_in(1, 0, 1, 0, 0, 0, 0, 0, 0); tick();
        chk("trap flag", 64'(out_trap), 1);
        chk("trap rd_addr", 64'(out_rd_addr), 0);
        chk("trap rd_wdata", 64'(out_rd_wdata), 0);
        chk("trap rmask", 64'(out_mem_rmask), 0);
        chk("trap wmask", 64'(out_mem_wmask), 0);
        chk("trap order", out_order, 1);
        chk("trap mem_addr", 64'(out_mem_addr), 64'(32'h2004 ^ 32'h8000_0000));

        // ---- reset with 4 queued and overflow set ----
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 9; i++) begin
            set_in(1, 1, 0, 32'h3000 + 32'(i), 0, 5'd1, 32'h1, 0, 0); tick();
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 1, 0, 0, 0, 0, 0, 0); tick();
        end
        chk("pre-reset count", 64'(count), 4);
        chk("pre-reset overflow", 64'(overflow), 1);
        set_in(0, 1, 1, 32'h4444, 0, 5'd1, 32'h1, 0, 0); tick();
        chk("rst count", 64'(count), 0);
        chk("rst valid", 64'(out_valid), 0);
        chk("rst overflow", 64'(overflow), 0);
        chk("rst drops", 64'(drop_count), 0);
        chk("rst halt", 64'(halt_req), 0);
        set_in(1, 1, 0, 32'h5000, 0, 5'd1, 32'h1, 0, 0); tick();
        chk("post-rst order", out_order, 0);
        chk("post-rst pc", 64'(out_pc_rdata), 64'h5000);

        // ---- random traffic against the model ----
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); model_step();
        for (int c = 0; c < 3000; c++) begin
            int ph;
            logic r_rst, r_rv, r_rdy;
            ph    = (c / 250) % 3;
            r_rst = ($urandom_range(0, 399) != 0);
            r_rv  = ($urandom_range(0, 3) != 0);
            r_rdy = (ph == 0) ? ($urandom_range(0, 3) == 0) :
                    (ph == 1) ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1) == 1;
            set_in(r_rst, r_rv, r_rdy, $urandom, $urandom_range(0, 5) == 0,
                   5'($urandom_range(0, 31)), $urandom, 4'($urandom), 4'($urandom));
            tick();
            model_step();
            chk("rnd count", 64'(count), 64'(mq.size()));
            chk("rnd valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("rnd halt", 64'(halt_req), 64'(m_halt));
            chk("rnd overflow", 64'(overflow), 64'(m_ov));
            chk("rnd drops", 64'(drop_count), 64'(m_drop));
            if (mq.size() != 0) begin
                chk("rnd order", out_order, mq[0].order);
                chk("rnd pc_rdata", 64'(out_pc_rdata), 64'(mq[0].pc_rdata));
                chk("rnd pc_wdata", 64'(out_pc_wdata), 64'(mq[0].pc_wdata));
                chk("rnd insn", 64'(out_insn), 64'(mq[0].insn));
                chk("rnd trap", 64'(out_trap), 64'(mq[0].trap));
                chk("rnd rd_addr", 64'(out_rd_addr), 64'(mq[0].rd_addr));
                chk("rnd rd_wdata", 64'(out_rd_wdata), 64'(mq[0].rd_wdata));
                chk("rnd mem_addr", 64'(out_mem_addr), 64'(mq[0].mem_addr));
                chk("rnd rmask", 64'(out_mem_rmask), 64'(mq[0].rmask));
                chk("rnd wmask", 64'(out_mem_wmask), 64'(mq[0].wmask));
                chk("rnd mem_rdata", 64'(out_mem_rdata), 64'(mq[0].mem_rdata));
                chk("rnd mem_wdata", 64'(out_mem_wdata), 64'(mq[0].mem_wdata));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rvfi_trace_fifo.md
# rvfi_trace_fifo

Retirement-trace buffer between the rv32i core's retirement point and the RVFI-DII/RVFI-ext host consumer. Each cycle the core retires an instruction, the block captures one RVFI execution packet, stamps it with a monotonically increasing 64-bit order number and queues it. The consumer drains packets over a valid/ready handshake. When the queue nears capacity the block requests a core halt; any packet lost to overflow is counted and flagged.

## Interface
Parameters:
- DEPTH, 8 — packet slots; power of two, 2..64.
- HALT_MARGIN, 2 — `halt_req` asserts when occupancy ≥ DEPTH − HALT_MARGIN; range 1..DEPTH−1.

Ports:
- clk  in  1  — core clock; all state updates on its rising edge.
- rst_n  in  1  — reset, synchronous, active-low.
- ret_valid  in  1  — one instruction retires this cycle.
- ret_pc_rdata  in  32  — PC of the retiring instruction.
- ret_pc_wdata  in  32  — next PC, trap-adjusted.
- ret_insn  in  32  — instruction word.
- ret_trap  in  1  — instruction trapped.
- ret_rd_addr  in  5  — destination register.
- ret_rd_wdata  in  32  — destination write data.
- ret_mem_addr  in  32  — memory address.
- ret_mem_rmask  in  4  — load byte mask.
- ret_mem_wmask  in  4  — store byte mask.
- ret_mem_rdata  in  32  — load data.
- ret_mem_wdata  in  32  — store data.
- out_valid  out  1  — head packet is valid.
- out_ready  in  1  — consumer accepts the head packet.
- out_order  out  64  — order number of the head packet.
- out_pc_rdata, out_pc_wdata, out_insn, out_trap, out_rd_addr, out_rd_wdata, out_mem_addr, out_mem_rmask, out_mem_wmask, out_mem_rdata, out_mem_wdata  out  as inputs  — head packet fields.
- count  out  $clog2(DEPTH)+1  — current occupancy.
- halt_req  out  1  — registered backpressure request to the core.
- overflow  out  1  — sticky: at least one packet dropped.
- drop_count  out  16  — dropped packets, saturating at 0xFFFF.

## Operation
- Push: occurs when `ret_valid` is high and either count < DEPTH or a pop happens in the same cycle. Otherwise `ret_valid` drops the packet: `overflow` is set and `drop_count` increments, saturating at 0xFFFF.
- Pop: occurs when `out_valid && out_ready`. The head advances.
- Packet sanitisation happens at capture:
  - `ret_rd_addr == 0` stores rd_wdata as 0.
  - `ret_trap` stores rd_addr, rd_wdata, mem_rmask and mem_wmask as 0.
  - Other fields are stored verbatim.
- Order counter: a 64-bit register. Each accepted push stamps the current value and then increments it. Dropped packets do not consume an order number, so they are detected only through `drop_count`. The counter wraps from 2^64−1 to 0.
- Storage: a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Occupancy is tracked in `count`.
- Output is first-word-fall-through: `out_*` always reflect the head slot, and `out_valid = (count != 0)`. Outputs hold stable while `out_valid && !out_ready`.
- `halt_req` is a register, updated every cycle to (next_count ≥ DEPTH − HALT_MARGIN).
- Reset values (rst_n low at a clock edge): pointers, count, order, `overflow`, `drop_count` and `halt_req` are all 0. `out_valid` is 0. Stored packet contents are don't-care.
- Reset mid-operation: all queued packets are discarded and the order restarts at 0. Inputs are ignored in any cycle where rst_n is low.

## Timing
- Push-to-visible latency is 1 cycle. A packet pushed at edge N appears on `out_*` with `out_valid` high after edge N; it is poppable in cycle N+1 at the earliest.
- Pop takes effect at the edge. The next packet, if present, is visible in the following cycle, giving a sustained throughput of 1 push and 1 pop per cycle.
- Simultaneous push and pop:
  - count is unchanged.
  - This is permitted when full, with no drop.
  - When empty, there is no pop, because `out_valid` is 0 and there is no bypass.
- `halt_req` rises in the cycle after the push that reaches the threshold. It falls in the cycle after the pop that goes below it.
- HALT_MARGIN ≥ 1 covers the 1-cycle halt response of the core. If the core fails to honour it, the overflow path applies.
- Full boundary: with count = DEPTH, a `ret_valid` with no pop drops the packet. With count = DEPTH and a pop in the same cycle, the push is accepted.
- `overflow` and `drop_count` update at the edge of the dropping cycle.

## Test plan
- Reset, then 3 pushes with `out_ready` = 0 → count = 3; `out_order` = 0 with `out_pc_rdata` of the first packet; `halt_req` = 0 for DEPTH = 8, HALT_MARGIN = 2.
- Drain 3 with `out_ready` = 1 → order sequence 0, 1, 2 with fields matching the inputs; count = 0; `out_valid` = 0 after the third pop.
- Push 6 with no pop → `halt_req` = 1 in the cycle after the 6th push. Then pop 1 → `halt_req` = 0 one cycle after that pop.
- Fill to 8, then push 2 more with no pop → `overflow` = 1, `drop_count` = 2, count = 8. Then push and pop in the same cycle → accepted with `out_order` continuity 0..7 then 8, and `drop_count` stays 2.
- Push a packet with rd_addr = 0, rd_wdata = 0xDEADBEEF, and a trapped packet with rmask = 0xF, rd_addr = 5 → the first outputs rd_wdata = 0; the second outputs rd_addr = 0, rd_wdata = 0, rmask = 0, wmask = 0.
- Reset asserted with 4 queued and `overflow` = 1 → after the edge: count = 0, `out_valid` = 0, `overflow` = 0, `drop_count` = 0; the next push has `out_order` = 0.
